// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO in fixed-length bursts onto a valid/ready stream with a last marker.
// Latency: the count condition is seen in IDLE at cycle N, the first fifo_re is at N+1 and the first m_valid at N+2.
// Backpressure: a 2-entry skid buffer absorbs stalls, and popping stops while it is full. fifo_re never depends on m_ready.
//
// Ports:
//   clk, reset             clock (rising edge) and asynchronous active-high reset
//   fifo_re                pop strobe to the FIFO (combinational)
//   fifo_dout/empty/count  FIFO head word, empty flag and occupancy
//   burst_len              words per burst, sampled when a burst starts
//   m_valid/data/last      output stream
//   m_ready                downstream accept
//   busy                   high when a burst is in progress or the skid buffer holds data
//   bursts_done            count of completed bursts, wraps modulo 2^32
//
// Optional feature: define FIFO_READER_TIMEOUT_EN to flush a partial burst after the FIFO
// has held 0 < fifo_count < burst_len for TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   fifo_re,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  input  logic [15:0]            burst_len,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [31:0]            bursts_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Common width for the zero-extended occupancy/length compare.
  localparam int CW = (COUNT_WIDTH > 16) ? COUNT_WIDTH : 16;

  state_t            state_q, state_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [1:0]        occ_q, occ_d;
  logic [WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [31:0]       bursts_q, bursts_d;

  logic [CW-1:0]     count_ext;
  logic [CW-1:0]     len_ext;
  logic              full_ready;
  logic              push;
  logic              pop;
  logic [1:0]        wr_idx;

  assign count_ext  = CW'(fifo_count);
  assign len_ext    = CW'(burst_len);
  assign full_ready = (burst_len != 16'd0) && (count_ext >= len_ext);

  assign fifo_re     = (state_q == BURST) && !fifo_empty && (remaining_q != 16'd0) && (occ_q < 2'd2);
  assign push        = fifo_re;
  assign m_valid     = (occ_q != 2'd0);
  assign m_data      = data0_q;
  assign m_last      = last0_q;
  assign pop         = m_valid && m_ready;
  assign busy        = (state_q != IDLE) || (occ_q != 2'd0);
  assign bursts_done = bursts_q;

  // Slot the new word lands in once this cycle's pop has shifted the buffer.
  assign wr_idx = occ_q - {1'b0, pop};

`ifdef FIFO_READER_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic        partial_cond;

  assign partial_cond = (count_ext != '0) && (count_ext < len_ext);

  always_comb begin
    timer_d = 16'd0;
    if ((state_q == IDLE) && partial_cond && (timer_q != 16'(TIMEOUT - 1))) begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= 16'd0;
    else       timer_q <= timer_d;
  end
`endif

  // Burst control
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (full_ready) begin
          state_d     = BURST;
          remaining_d = burst_len;
        end
`ifdef FIFO_READER_TIMEOUT_EN
        else if (partial_cond && (timer_q == 16'(TIMEOUT - 1))) begin
          // Partial flush. The occupancy is below burst_len here, so it fits in 16 bits.
          state_d     = BURST;
          remaining_d = count_ext[15:0];
        end
`endif
      end
      BURST: begin
        if (push) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: slot 0 is the head. A pop shifts slot 1 forward.
  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    last0_d  = last0_q;
    last1_d  = last1_q;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    bursts_d = bursts_q;
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
      if (last0_q) bursts_d = bursts_q + 32'd1;
    end
    if (push) begin
      if (wr_idx == 2'd0) begin
        data0_d = fifo_dout;
        last0_d = (remaining_q == 16'd1);
      end else begin
        data1_d = fifo_dout;
        last1_d = (remaining_q == 16'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 16'd0;
      occ_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      bursts_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      bursts_q    <= bursts_d;
    end
  end

endmodule
